// File: rtl/mips_mem_resp.sv
// Word-addressed data memory responder with fixed wait states and valid/ready handshakes.
// Optional bounds check: define MIPS_MEM_RESP_BOUNDS_CHECK_EN to flag req_addr >= DEPTH.
module mips_mem_resp #(
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            oor_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     mem [DEPTH];

    logic            oor_d;
    logic            access;

`ifdef MIPS_MEM_RESP_BOUNDS_CHECK_EN
    assign oor_d = |req_addr[31:AW];
`else
    // Upper address bits are dropped so the index wraps modulo DEPTH.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:AW];
    assign oor_d = 1'b0;
`endif

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign access    = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // Storage is never reset; a reset between edges drops state to IDLE first.
    always_ff @(posedge clk1) begin
        if (access && we_q && !oor_q && !rst) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            oor_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        idx_q   <= req_addr[AW-1:0];
                        wdata_q <= req_wdata;
                        oor_q   <= oor_d;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= oor_q;
                        rsp_rdata_q <= (we_q || oor_q) ? 32'd0 : mem[idx_q];
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_resp.sv
// Randomized self-checking bench for mips_mem_resp against an associative-array memory model.
// Covers latency, backpressure, reset mid-access, wraparound/bounds and zero wait states.
module tb_mips_mem_resp;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int WC    = 2;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_we, z_rsp_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
    logic [31:0] z_rsp_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ecnt    = 0;

    logic [31:0] mdl [int];

    always #5 clk1 = ~clk1;
    always @(posedge clk1) ecnt <= ecnt + 1;

    mips_mem_resp #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(WC)) u_dut (
        .clk1(clk1), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    mips_mem_resp #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(0)) u_dut0 (
        .clk1(clk1), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .busy(z_busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: what one request should return and do to memory.
    task automatic model(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output logic err, output bit known);
        int idx;
        idx = int'(addr % DEPTH);
`ifdef MIPS_MEM_RESP_BOUNDS_CHECK_EN
        err = (addr >= DEPTH);
`else
        err = 1'b0;
`endif
        known = 1'b1;
        rd = 32'd0;
        if (!err) begin
            if (we) mdl[idx] = wdata;
            else if (mdl.exists(idx)) rd = mdl[idx];
            else known = 1'b0;
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          input bit garbage);
        logic [31:0] erd, rd0;
        logic        eerr;
        bit          known;
        int          n;
        model(we, addr, wdata, erd, eerr, known);
        @(negedge clk1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk1);
        #1;
        req_valid = garbage;
        n = 0;
        while (n < 40) begin
            @(posedge clk1);
            #1;
            n++;
            if (rsp_valid) break;
            if (garbage) begin
                req_valid = 1'($urandom);
                req_we    = 1'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        check("latency", n, WC + 1);
        check("busy_resp", 32'(busy), 32'd1);
        check("rsp_err", 32'(rsp_err), 32'(eerr));
        if (known) check("rsp_rdata", rsp_rdata, erd);
        rd0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk1);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, rd0);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk1);
        rsp_ready = 1'b1;
        @(posedge clk1);
        #1;
        rsp_ready = 1'b0;
        check("rsp_cleared", 32'(rsp_valid), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a, zd;
        int          prev;
        logic [31:0] wlist [$];

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0;
        z_req_wdata = '0; z_rsp_ready = 1'b1;
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk1);
        rst = 1'b0;

        do_req(1'b1, 32'd5, 32'h0000_00AA, 0, 0);
        do_req(1'b0, 32'd5, 32'h0, 0, 0);

        do_req(1'b1, 32'd7, 32'h1234_5678, 0, 0);
        do_req(1'b0, 32'd7, 32'h0, 5, 0);

        // Abandoned store must leave the previously written zero in place.
        do_req(1'b1, 32'd9, 32'h0, 0, 0);
        @(negedge clk1);
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = 32'd9; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk1);
        #1;
        req_valid = 1'b0;
        @(posedge clk1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        do_req(1'b0, 32'd9, 32'h0, 0, 0);

        do_req(1'b1, 32'd1, 32'h0000_0011, 0, 0);
        do_req(1'b1, 32'd1025, 32'h55, 0, 0);
        do_req(1'b0, 32'd1, 32'h0, 0, 0);

        do_req(1'b1, 32'd20, 32'hCAFE_F00D, 0, 1);
        do_req(1'b0, 32'd20, 32'h0, 1, 1);

        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(0, 2 * DEPTH - 1);
            wlist.push_back(a);
            do_req(1'b1, a, $urandom, $urandom_range(0, 2), 1'($urandom));
        end
        for (int i = 0; i < 20; i++) begin
            a = wlist[$urandom_range(0, 19)] % DEPTH;
            a = a + DEPTH * $urandom_range(0, 1);
            do_req(1'b0, a, 32'h0, $urandom_range(0, 2), 1'($urandom));
        end

        prev = 0;
        zd = 32'h0;
        z_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk1);
            z_req_we   = (k % 2 == 0);
            z_req_addr = 32'(k / 2);
            if (k % 2 == 0) begin
                zd = $urandom;
                z_req_wdata = zd;
            end
            check("z_ready", 32'(z_req_ready), 32'd1);
            @(posedge clk1);
            #1;
            if (k > 0) check("z_spacing", ecnt - prev, 3);
            prev = ecnt;
            @(posedge clk1);
            #1;
            check("z_latency", 32'(z_rsp_valid), 32'd1);
            check("z_rdata", z_rsp_rdata, (k % 2 == 0) ? 32'd0 : zd);
            @(posedge clk1);
        end
        z_req_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_resp.md
# mips_mem_resp

Word-addressed data-memory responder serving load/store requests from the pipelined MIPS core over a valid/ready request and response handshake. It stores 32-bit words and accepts one request at a time. Each access takes a fixed, parameterised number of wait states, which models slow memory behind the pipeline. It sits between the core's MEM stage and the backing storage, and owns the storage array.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words.
- AW, 10, index width; DEPTH = 2**AW.
- WAIT_CYCLES, 2, wait states per access; legal range 0..15.

Ports:
- clk1  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; equals (state==IDLE) && !rst.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  32  word address; equals the core's ALUout.
- req_wdata  in  32  store data; equals the core's B operand.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  address out of range; see Configuration.
- busy  out  1  high in WAIT or RESP.

## Operation
- FSM states are IDLE, WAIT and RESP. Reset enters IDLE.
- IDLE:
  - On req_valid && req_ready, latch req_we, req_addr and req_wdata.
  - Load cnt = WAIT_CYCLES and go to WAIT.
- WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, perform the access in that edge and go to RESP with rsp_valid=1.
  - Load: rsp_rdata = mem[index].
  - Store: mem[index] = wdata and rsp_rdata = 0.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that edge, clear rsp_valid and return to IDLE.
  - A new request is accepted no earlier than the following edge.
- Request inputs are ignored outside IDLE. Latched values cannot be altered mid-access.
- Index is addr[AW-1:0]. A store followed by a load to the same address returns the stored word.
- The storage array is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values (asynchronous): state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0 while rst is high.
- Request accepted at edge N:
  - The access occurs at edge N+WAIT_CYCLES+1.
  - rsp_valid is high from that edge.
  - Latency is WAIT_CYCLES+1 cycles.
- WAIT_CYCLES=0 gives a 1-cycle response.
- With rsp_ready held high, the minimum request-to-request spacing is WAIT_CYCLES+3 edges.
- Simultaneous req_valid during a RESP handshake is not accepted. req_ready is low in RESP.
- Reset during WAIT:
  - The access is abandoned and no memory write occurs.
  - rsp_valid=0 and state=IDLE immediately.
- Reset during RESP:
  - The response is dropped.
  - A store already committed at the access edge remains in memory.
- rsp_ready high while rsp_valid is low has no effect.

## Configuration
- MIPS_MEM_RESP_BOUNDS_CHECK_EN defined:
  - Any request with req_addr >= DEPTH completes with normal latency and sets rsp_err=1.
  - The store is suppressed and rsp_rdata=0.
  - In-range requests return rsp_err=0.
- Not defined:
  - rsp_err is tied to 0.
  - Upper address bits are discarded and the index wraps modulo DEPTH, e.g. addr 1025 maps to word 1.

## Test plan
- Load after reset and write:
  - Stimulus: after reset, WAIT_CYCLES=2; store addr 5, data 32'h0000_00AA; then load addr 5.
  - Required: both responses assert rsp_valid exactly 3 cycles after acceptance; the load returns 32'h0000_00AA and the store returns rsp_rdata=0.
- Response backpressure:
  - Stimulus: load addr 7 (preloaded 32'h1234_5678) with rsp_ready held low for 5 cycles.
  - Required: rsp_valid and rsp_rdata stay stable and req_ready stays 0 throughout; the handshake on cycle 6 returns the FSM to IDLE.
- Zero wait states:
  - Stimulus: WAIT_CYCLES=0; back-to-back requests with rsp_ready=1.
  - Required: each response arrives 1 cycle after acceptance; requests are accepted every 3 edges.
- Reset mid-access:
  - Stimulus: store addr 9, data 32'hDEAD_BEEF; assert rst during WAIT; then load addr 9 with a known prior value of 32'h0.
  - Required: the load returns 32'h0, and rsp_valid is 0 immediately on rst.
- Out-of-range address:
  - Stimulus: store to addr 1025, data 32'h55.
  - Required with the macro: rsp_err=1 and word 1 is unchanged.
  - Required without the macro: rsp_err=0, and a load of addr 1 returns 32'h55.
- Ignored inputs:
  - Stimulus: toggle req_valid, req_addr and req_wdata during WAIT.
  - Required: no extra accept, and the response reflects the originally latched request.
